// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding and bus-level constants.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_REG,
        ST_REG_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_WAIT_STOP
    } i2c_state_t;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;
    localparam logic I2C_ACK      = 1'b0;
    localparam logic I2C_NACK     = 1'b1;

endpackage

// File: rtl/i2c_line_cond.sv
// SCL/SDA conditioning: 2-flop sync, optional glitch filter, edge/START/STOP.
// Define I2C_SLAVE_GLITCH_FILTER_EN to enable the FILT_LEN stability filter.
module i2c_line_cond #(
    parameter int unsigned FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    // bit 0 = SCL, bit 1 = SDA
    logic [1:0] s1_q, s2_q;
    logic [1:0] lvl;
    logic [1:0] prev_q;

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILT_LEN + 1);

    logic [1:0]    filt_q, filt_d;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];

    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != filt_q[i]) begin
                if (cnt_q[i] == CW'(FILT_LEN - 1)) begin
                    filt_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            filt_q <= 2'b11;
            cnt_q  <= '{default: '0};
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = s2_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q   <= 2'b11;
            s2_q   <= 2'b11;
            prev_q <= 2'b11;
        end else begin
            s1_q   <= {sda_i, scl_i};
            s2_q   <= s1_q;
            prev_q <= lvl;
        end
    end

    assign scl_rise  = lvl[0] & ~prev_q[0];
    assign scl_fall  = ~lvl[0] & prev_q[0];
    assign start_det = lvl[0] & prev_q[0] & prev_q[1] & ~lvl[1];
    assign stop_det  = lvl[0] & prev_q[0] & ~prev_q[1] & lvl[1];
    assign sda_s     = lvl[1];

endmodule

// File: rtl/i2c_slave.sv
// 7-bit I2C target bridging bus transfers to an 8-bit register bank.
// Define I2C_SLAVE_GLITCH_FILTER_EN to filter SCL/SDA glitches.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR = 7'h50,
    parameter int unsigned FILT_LEN   = 3
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        scl,
    inout  wire        sda,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr_en,
    output logic       reg_rd_en,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       addr_hit
);

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_line_cond #(
        .FILT_LEN(FILT_LEN)
    ) u_line_cond (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (scl),
        .sda_i    (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det),
        .sda_s    (sda_s)
    );

    i2c_state_t state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       phase_q, phase_d;
    logic       rw_q, rw_d;
    logic       ptr_q, ptr_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] reg_addr_q, reg_addr_d;
    logic [7:0] reg_wdata_q, reg_wdata_d;
    logic       reg_wr_en_q, reg_wr_en_d;
    logic       reg_rd_en_q, reg_rd_en_d;
    logic       busy_q, busy_d;
    logic       addr_hit_q, addr_hit_d;

    logic [7:0] byte_in;
    logic       last_bit;

    assign byte_in  = {shift_q[6:0], sda_s};
    assign last_bit = (bit_cnt_q == 3'd0);

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        phase_d     = phase_q;
        rw_d        = rw_q;
        ptr_d       = ptr_q;
        sda_oe_d    = sda_oe_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_wr_en_d = 1'b0;
        reg_rd_en_d = 1'b0;
        busy_d      = busy_q;
        addr_hit_d  = 1'b0;

        if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 3'd7;
            phase_d   = 1'b0;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            state_d  = ST_IDLE;
            phase_d  = 1'b0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            ptr_d    = 1'b0;
        end else begin
            unique case (state_q)
                ST_ADDR, ST_REG, ST_WDATA: begin
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q - 3'd1;
                        if (last_bit) begin
                            if (state_q == ST_REG) begin
                                reg_addr_d = byte_in;
                                ptr_d      = 1'b1;
                                state_d    = ST_REG_ACK;
                            end else if (state_q == ST_WDATA) begin
                                reg_wdata_d = byte_in;
                                reg_wr_en_d = 1'b1;
                                state_d     = ST_WDATA_ACK;
                            end else if (byte_in[7:1] == SLAVE_ADDR) begin
                                rw_d       = byte_in[0];
                                addr_hit_d = 1'b1;
                                busy_d     = 1'b1;
                                state_d    = ST_ADDR_ACK;
                            end else begin
                                busy_d  = 1'b0;
                                state_d = ST_WAIT_STOP;
                            end
                        end
                    end
                end
                // First fall drives ACK, second fall releases and moves on.
                ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        phase_d   = ~phase_q;
                        sda_oe_d  = ~phase_q;
                        bit_cnt_d = 3'd7;
                        if (phase_q) begin
                            if (state_q == ST_WDATA_ACK) begin
                                reg_addr_d = reg_addr_q + 8'd1;
                                state_d    = ST_WDATA;
                            end else if (state_q == ST_REG_ACK) begin
                                state_d = ST_WDATA;
                            end else if (rw_q == I2C_RW_WRITE) begin
                                state_d = ptr_q ? ST_WDATA : ST_REG;
                            end else begin
                                reg_rd_en_d = 1'b1;
                                shift_d     = reg_rdata;
                                sda_oe_d    = ~reg_rdata[7];
                                state_d     = ST_RDATA;
                            end
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_rise) begin
                        if (last_bit) begin
                            phase_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q - 3'd1;
                        end
                    end else if (scl_fall) begin
                        if (phase_q) begin
                            phase_d  = 1'b0;
                            sda_oe_d = 1'b0;
                            state_d  = ST_RDATA_ACK;
                        end else begin
                            sda_oe_d = ~shift_q[bit_cnt_q];
                        end
                    end
                end
                // Pointer bumps on the ACK rise so reg_rdata settles by the fall.
                ST_RDATA_ACK: begin
                    if (scl_rise && !phase_q) begin
                        if (sda_s == I2C_NACK) begin
                            state_d = ST_WAIT_STOP;
                        end else begin
                            phase_d    = 1'b1;
                            reg_addr_d = reg_addr_q + 8'd1;
                        end
                    end else if (scl_fall && phase_q) begin
                        phase_d     = 1'b0;
                        bit_cnt_d   = 3'd7;
                        reg_rd_en_d = 1'b1;
                        shift_d     = reg_rdata;
                        sda_oe_d    = ~reg_rdata[7];
                        state_d     = ST_RDATA;
                    end
                end
                ST_IDLE, ST_WAIT_STOP: begin
                end
                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= 8'h00;
            bit_cnt_q   <= 3'd7;
            phase_q     <= 1'b0;
            rw_q        <= 1'b0;
            ptr_q       <= 1'b0;
            sda_oe_q    <= 1'b0;
            reg_addr_q  <= 8'h00;
            reg_wdata_q <= 8'h00;
            reg_wr_en_q <= 1'b0;
            reg_rd_en_q <= 1'b0;
            busy_q      <= 1'b0;
            addr_hit_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            phase_q     <= phase_d;
            rw_q        <= rw_d;
            ptr_q       <= ptr_d;
            sda_oe_q    <= sda_oe_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_wr_en_q <= reg_wr_en_d;
            reg_rd_en_q <= reg_rd_en_d;
            busy_q      <= busy_d;
            addr_hit_q  <= addr_hit_d;
        end
    end

    assign sda       = sda_oe_q ? 1'b0 : 1'bz;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_wr_en = reg_wr_en_q;
    assign reg_rd_en = reg_rd_en_q;
    assign busy      = busy_q;
    assign addr_hit  = addr_hit_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: bit-banged master, register bank model.
// Covers write, burst wrap, read, mismatch, abort and mid-read reset.
module tb_i2c_slave;

    localparam int Q = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    wire        scl;
    wire        sda;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic       reg_wr_en, reg_rd_en, busy, addr_hit;

    logic [7:0] bank [256];
    logic [7:0] wr_a[$], wr_d[$], rd_a[$];
    int         hit_cnt = 0;
    bit         slave_low = 1'b0;
    bit         busy_seen = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    assign scl = m_scl;
    assign sda = m_sda ? 1'bz : 1'b0;
    pullup (sda);

    assign reg_rdata = bank[reg_addr];

    always #5 clk = ~clk;

    i2c_slave dut (
        .clk      (clk),
        .rst      (rst),
        .scl      (scl),
        .sda      (sda),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .reg_wr_en(reg_wr_en),
        .reg_rd_en(reg_rd_en),
        .reg_rdata(reg_rdata),
        .busy     (busy),
        .addr_hit (addr_hit)
    );

    always @(negedge clk) begin
        if (reg_wr_en) begin
            wr_a.push_back(reg_addr);
            wr_d.push_back(reg_wdata);
        end
        if (reg_rd_en) rd_a.push_back(reg_addr);
        if (addr_hit) hit_cnt++;
        if (busy) busy_seen = 1'b1;
        if (m_sda && sda === 1'b0) slave_low = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic clear_logs();
        wr_a.delete();
        wr_d.delete();
        rd_a.delete();
        hit_cnt   = 0;
        slave_low = 1'b0;
        busy_seen = 1'b0;
    endtask

    task automatic bus_start();
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b1; tick(Q);
    endtask

    task automatic send_bit(input logic b);
        m_sda = b;    tick(Q);
        m_scl = 1'b1; tick(2 * Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic recv_bit(output logic b);
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        b = sda;      tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic ack);
        for (int i = 7; i >= 0; i--) recv_bit(d[i]);
        send_bit(ack);
    endtask

    logic       ack;
    logic [7:0] rdat;
    logic [2:0] acks;

    initial begin
        for (int i = 0; i < 256; i++) bank[i] = 8'(i);
        bank[8'h20] = 8'hC3;
        bank[8'h05] = 8'h00;

        rst = 1'b0;
        tick(5);
        @(negedge clk);
        check("rst_ctl", {28'd0, busy, addr_hit, reg_wr_en, reg_rd_en}, 0);
        check("rst_addr", {24'd0, reg_addr}, 32'h00);
        check("rst_wdata", {24'd0, reg_wdata}, 32'h00);
        check("rst_sda", {31'd0, sda}, 1);
        rst = 1'b1;
        tick(5);

        // single write
        clear_logs();
        bus_start();
        send_byte(8'hA0, acks[0]);
        @(negedge clk);
        check("wr_busy", {31'd0, busy}, 1);
        check("wr_hit", hit_cnt, 1);
        send_byte(8'h10, acks[1]);
        send_byte(8'h5A, acks[2]);
        bus_stop();
        tick(10);
        check("wr_acks", {29'd0, acks}, 0);
        check("wr_cnt", wr_a.size(), 1);
        check("wr_a0", {24'd0, wr_a[0]}, 32'h10);
        check("wr_d0", {24'd0, wr_d[0]}, 32'h5A);
        check("wr_ptr", {24'd0, reg_addr}, 32'h11);
        check("wr_busy_end", {31'd0, busy}, 0);

        // burst write with pointer wrap
        clear_logs();
        bus_start();
        send_byte(8'hA0, acks[0]);
        send_byte(8'hFF, acks[1]);
        send_byte(8'h11, acks[2]);
        send_byte(8'h22, ack);
        bus_stop();
        tick(10);
        check("bw_acks", {28'd0, acks, ack}, 0);
        check("bw_cnt", wr_a.size(), 2);
        check("bw_w0", {16'd0, wr_a[0], wr_d[0]}, 32'hFF11);
        check("bw_w1", {16'd0, wr_a[1], wr_d[1]}, 32'h0022);
        check("bw_ptr", {24'd0, reg_addr}, 32'h01);

        // read with repeated START
        clear_logs();
        bus_start();
        send_byte(8'hA0, acks[0]);
        send_byte(8'h20, acks[1]);
        bus_start();
        send_byte(8'hA1, acks[2]);
        recv_byte(rdat, 1'b1);
        @(negedge clk);
        check("rd_sda_rel", {31'd0, sda}, 1);
        bus_stop();
        tick(10);
        check("rd_acks", {29'd0, acks}, 0);
        check("rd_data", {24'd0, rdat}, 32'hC3);
        check("rd_cnt", rd_a.size(), 1);
        check("rd_a0", {24'd0, rd_a[0]}, 32'h20);
        check("rd_wr_cnt", wr_a.size(), 0);
        check("rd_busy_end", {31'd0, busy}, 0);

        // address mismatch
        clear_logs();
        bus_start();
        send_byte(8'hA2, acks[0]);
        send_byte(8'h10, acks[1]);
        send_byte(8'h99, acks[2]);
        bus_stop();
        tick(10);
        check("mm_acks", {29'd0, acks}, 32'h7);
        check("mm_sda_low", {31'd0, slave_low}, 0);
        check("mm_strobes", wr_a.size() + rd_a.size(), 0);
        check("mm_hit", hit_cnt, 0);
        check("mm_busy", {31'd0, busy_seen}, 0);

        // abort mid data byte, then a full write
        clear_logs();
        bus_start();
        send_byte(8'hA0, acks[0]);
        send_byte(8'h30, acks[1]);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        bus_stop();
        tick(10);
        check("ab_wr_cnt", wr_a.size(), 0);
        check("ab_busy", {31'd0, busy}, 0);
        bus_start();
        send_byte(8'hA0, acks[0]);
        send_byte(8'h40, acks[1]);
        send_byte(8'h77, acks[2]);
        bus_stop();
        tick(10);
        check("ab2_acks", {29'd0, acks}, 0);
        check("ab2_cnt", wr_a.size(), 1);
        check("ab2_w0", {16'd0, wr_a[0], wr_d[0]}, 32'h4077);

        // reset while slave drives a read bit low
        clear_logs();
        bus_start();
        send_byte(8'hA0, acks[0]);
        send_byte(8'h05, acks[1]);
        bus_start();
        send_byte(8'hA1, acks[2]);
        tick(Q);
        @(negedge clk);
        check("rs_drive", {31'd0, sda}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rs_sda", {31'd0, sda}, 1);
        check("rs_ctl", {28'd0, busy, addr_hit, reg_wr_en, reg_rd_en}, 0);
        check("rs_regs", {16'd0, reg_addr, reg_wdata}, 0);
        tick(3);
        rst = 1'b1;
        bus_stop();
        tick(10);
        check("rs_idle", {31'd0, busy}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
